// File: rtl/video_src_switch_ctrl_pkg.sv
// Shared types and constants for the HDMI TX source switchover controller.
package video_src_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BLANK,
        ST_RESET,
        ST_WAIT_LOCK,
        ST_WAIT_VS,
        ST_DONE
    } state_t;

    localparam logic SRC_VG = 1'b0;
    localparam logic SRC_SC = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// N-flop synchronizer for an asynchronous level, plus a one-cycle rising-edge pulse.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk27,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              level_d;

    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], async_in};
            level_d <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~level_d;

endmodule

// File: rtl/video_src_switch_ctrl.sv
// Sequences blank -> source select/reset -> PLL lock -> VSYNC check -> unblank
// when the requested HDMI TX source changes.
module video_src_switch_ctrl
    import video_src_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int BLANK_CYCLES   = 64,
    parameter int RST_CYCLES     = 16,
    parameter int VS_EDGES       = 2,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic clk27,
    input  logic reset_n,
    input  logic src_req,
    input  logic vsync_vg,
    input  logic vsync_sc,
    input  logic sc_pll_lock,
    output logic src_sel,
    output logic blank,
    output logic vg_reset_n,
    output logic sc_reset_n,
    output logic busy,
    output logic timeout_err
);

    localparam int CNT_W  = $clog2(max3(BLANK_CYCLES, RST_CYCLES, TIMEOUT_CYCLES));
    localparam int EDGE_W = $clog2(VS_EDGES + 1);

    localparam logic [CNT_W-1:0]  BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST    = EDGE_W'(VS_EDGES - 1);

    state_t            state;
    logic              target;
    logic              start_pending;
    logic [CNT_W-1:0]  cnt;
    logic [EDGE_W-1:0] edges;

    logic vg_rise, sc_rise, lock_level;
    logic vg_level_unused, sc_level_unused, lock_rise_unused;
    logic vs_rise, timed_out;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_vg (
        .clk27(clk27), .reset_n(reset_n), .async_in(vsync_vg),
        .level(vg_level_unused), .rise(vg_rise)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sc (
        .clk27(clk27), .reset_n(reset_n), .async_in(vsync_sc),
        .level(sc_level_unused), .rise(sc_rise)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk27(clk27), .reset_n(reset_n), .async_in(sc_pll_lock),
        .level(lock_level), .rise(lock_rise_unused)
    );

    assign vs_rise   = (target == SRC_SC) ? sc_rise : vg_rise;
    assign timed_out = (cnt == TIMEOUT_LAST);

    // start_pending forces one sequence after reset even when src_req matches src_sel.
    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            start_pending <= 1'b1;
            target        <= SRC_VG;
            cnt           <= '0;
            edges         <= '0;
            src_sel       <= SRC_VG;
            blank         <= 1'b1;
            vg_reset_n    <= 1'b0;
            sc_reset_n    <= 1'b1;
            busy          <= 1'b1;
            timeout_err   <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start_pending || (src_req != src_sel)) begin
                        start_pending <= 1'b0;
                        target        <= src_req;
                        timeout_err   <= 1'b0;
                        blank         <= 1'b1;
                        busy          <= 1'b1;
                        cnt           <= '0;
                        state         <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        src_sel    <= target;
                        vg_reset_n <= (target == SRC_VG);
                        sc_reset_n <= (target != SRC_SC);
                        cnt        <= '0;
                        state      <= ST_RESET;
                    end
                end
                ST_RESET: begin
                    if ((target == SRC_VG) || (cnt == RST_LAST)) begin
                        sc_reset_n <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if ((target == SRC_VG) || lock_level || timed_out) begin
                        if ((target == SRC_SC) && !lock_level) begin
                            timeout_err <= 1'b1;
                        end
                        cnt   <= '0;
                        edges <= '0;
                        state <= ST_WAIT_VS;
                    end
                end
                ST_WAIT_VS: begin
                    if (vs_rise && (edges == EDGE_LAST)) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else if (timed_out) begin
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_DONE;
                    end else if (vs_rise) begin
                        edges <= edges + 1'b1;
                    end
                end
                ST_DONE: begin
                    blank <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_src_switch_ctrl.sv
// Directed bench for video_src_switch_ctrl with a shortened timeout.
module tb_video_src_switch_ctrl;

    localparam int TMO = 200;

    logic clk27 = 1'b0;
    logic reset_n, src_req, vsync_vg, vsync_sc, sc_pll_lock;
    logic src_sel, blank, vg_reset_n, sc_reset_n, busy, timeout_err;
    logic [5:0] outs;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    video_src_switch_ctrl #(
        .SYNC_STAGES(2),
        .BLANK_CYCLES(64),
        .RST_CYCLES(16),
        .VS_EDGES(2),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk27(clk27),
        .reset_n(reset_n),
        .src_req(src_req),
        .vsync_vg(vsync_vg),
        .vsync_sc(vsync_sc),
        .sc_pll_lock(sc_pll_lock),
        .src_sel(src_sel),
        .blank(blank),
        .vg_reset_n(vg_reset_n),
        .sc_reset_n(sc_reset_n),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk27 = ~clk27;

    // {src_sel, blank, vg_reset_n, sc_reset_n, busy, timeout_err}
    assign outs = {src_sel, blank, vg_reset_n, sc_reset_n, busy, timeout_err};

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk27);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic vs_pulse(input logic sel);
        if (sel) vsync_sc = 1'b1; else vsync_vg = 1'b1;
        step(5);
        if (sel) vsync_sc = 1'b0; else vsync_vg = 1'b0;
        step(5);
    endtask

    initial begin
        logic prev_sel, prev_blank;
        reset_n = 1'b0; src_req = 1'b0;
        vsync_vg = 1'b0; vsync_sc = 1'b0; sc_pll_lock = 1'b0;
        step(3);
        chk("reset_values", outs, 6'b010110);

        // 1: power-up sequence onto videogen
        reset_n = 1'b1;
        step(1);  chk("t1_first_blank", outs, 6'b010110);
        step(63); chk("t1_blank_hold", outs, 6'b010110);
        step(1);  chk("t1_vg_release", outs, 6'b011110);
        step(5);
        vs_pulse(1'b0);
        vsync_vg = 1'b1;
        step(3);  chk("t1_done_still_blank", outs, 6'b011110);
        step(1);  chk("t1_unblank", outs, 6'b001100);
        vsync_vg = 1'b0;
        step(5);

        // 3: switch to scanconverter without PLL lock
        src_req = 1'b1;
        step(1);   chk("t3_blank_rise", outs, 6'b011110);
        step(64);  chk("t3_sel_switch", outs, 6'b110010);
        step(16);  chk("t3_wait_lock", outs, 6'b110110);
        step(199); chk("t3_pre_timeout", outs, 6'b110110);
        step(1);   chk("t3_lock_timeout", outs, 6'b110111);
        step(200); chk("t3_vs_timeout_blank", outs, 6'b110111);
        step(1);   chk("t3_unblank", outs, 6'b100101);

        // back to videogen; timeout_err clears at sequence start
        src_req = 1'b0;
        sc_pll_lock = 1'b1;
        step(1);  chk("back_start", outs, 6'b110110);
        step(64); chk("back_sel", outs, 6'b011110);
        step(3);
        vs_pulse(1'b0);
        vs_pulse(1'b0);
        chk("back_idle", outs, 6'b001100);

        // 2: locked switch to scanconverter, 4: toggle back during WAIT_VS
        src_req = 1'b1;
        step(1);  chk("t2_blank_1cyc", outs, 6'b011110);
        step(63); chk("t2_sel_hold", outs, 6'b011110);
        step(1);  chk("t2_sel_switch", outs, 6'b110010);
        step(15); chk("t2_screset_low", outs, 6'b110010);
        step(1);  chk("t2_screset_end", outs, 6'b110110);
        step(2);
        vs_pulse(1'b1);
        src_req = 1'b0;
        vsync_sc = 1'b1;
        step(3);  chk("t4_done_state", outs, 6'b110110);
        step(1);  chk("t4_unblank_pulse", outs, 6'b100100);
        vsync_sc = 1'b0;
        step(1);  chk("t4_restart", outs, 6'b110110);
        step(64); chk("t4_sel_vg", outs, 6'b011110);
        step(3);
        vs_pulse(1'b0);
        vs_pulse(1'b0);
        chk("t4_end_vg", outs, 6'b001100);

        // request glitch that returns before IDLE samples it
        src_req = 1'b1;
        #3;
        src_req = 1'b0;
        step(1);  chk("glitch_ignored", outs, 6'b001100);
        step(5);  chk("glitch_still_idle", outs, 6'b001100);

        // 5: reset during scanconverter RESET state
        src_req = 1'b1;
        step(65); chk("t5_in_reset_state", outs, 6'b110010);
        step(5);  chk("t5_reset_hold", outs, 6'b110010);
        reset_n = 1'b0;
        step(1);  chk("t5_reset", outs, 6'b010110);
        step(1);
        reset_n = 1'b1;
        step(1);  chk("t5_reenter", outs, 6'b010110);
        step(63); chk("t5_blank_count", outs, 6'b010110);
        step(1);  chk("t5_sel_switch", outs, 6'b110010);
        step(16); chk("t5_screset_end", outs, 6'b110110);
        step(2);
        vs_pulse(1'b1);
        vs_pulse(1'b1);
        chk("t5_end", outs, 6'b100100);

        // 6: random requests and vsync activity, invariants every cycle
        for (int i = 0; i < 3000; i++) begin
            prev_sel   = src_sel;
            prev_blank = blank;
            if ($urandom_range(0, 299) == 0) src_req = ~src_req;
            if ($urandom_range(0, 7) == 0) vsync_vg = ~vsync_vg;
            if ($urandom_range(0, 7) == 0) vsync_sc = ~vsync_sc;
            if ($urandom_range(0, 99) == 0) sc_pll_lock = ~sc_pll_lock;
            step(1);
            chk("t6_sel_while_unblanked",
                {5'b0, (prev_blank === 1'b1) || (src_sel === prev_sel)}, 6'b000001);
            chk("t6_vg_reset_invariant",
                {5'b0, (vg_reset_n === 1'b0) || (src_sel === 1'b0) || (busy === 1'b1)}, 6'b000001);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
